// File: rtl/regfile_preloader.sv
// Boot-time register image loader: writes FIRST_REG..LAST_REG, reads them back, compares XOR checksums, then releases the CPU.
// Writes take one word per cycle whenever load_valid is high during WRITE; readback always takes LAST_REG-FIRST_REG+1 cycles.
module regfile_preloader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READBACK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_A = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST_REG);
  localparam logic [ADDR_WIDTH:0]   FIRST_X = (ADDR_WIDTH + 1)'(FIRST_REG);
  localparam logic [ADDR_WIDTH:0]   LAST_X  = (ADDR_WIDTH + 1)'(LAST_REG);

  state_t                state;
  logic [DATA_WIDTH-1:0] wsum;
  logic [DATA_WIDTH-1:0] rsum;
  logic [DATA_WIDTH-1:0] rsum_next;
  logic                  in_range;
  logic                  accept;

  // Range guard keeps $r0 (and anything outside the image) unwritable even if the pointer were corrupted.
  assign in_range   = ({1'b0, rf_wr_addr} >= FIRST_X) && ({1'b0, rf_wr_addr} <= LAST_X);
  assign accept     = load_valid & load_ready & in_range;
  assign rf_we      = accept;
  assign rf_wr_data = load_data;
  assign rsum_next  = rsum ^ rf_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      load_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      rf_wr_addr <= FIRST_A;
      rf_rd_addr <= FIRST_A;
      wsum       <= '0;
      rsum       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_WRITE;
            load_ready <= 1'b1;
            rf_wr_addr <= FIRST_A;
            wsum       <= '0;
          end
        end
        S_WRITE: begin
          if (accept) begin
            wsum <= wsum ^ load_data;
            if (rf_wr_addr == LAST_A) begin
              state      <= S_READBACK;
              load_ready <= 1'b0;
              rf_rd_addr <= FIRST_A;
              rsum       <= '0;
            end else begin
              rf_wr_addr <= rf_wr_addr + 1'b1;
            end
          end
        end
        S_READBACK: begin
          rsum <= rsum_next;
          if (rf_rd_addr == LAST_A) begin
            if (rsum_next == wsum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end else begin
            rf_rd_addr <= rf_rd_addr + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        S_ERROR: begin
          // Retry is a full reload from the first register, not a resume.
          if (start) begin
            state      <= S_WRITE;
            error      <= 1'b0;
            load_ready <= 1'b1;
            rf_wr_addr <= FIRST_A;
            rf_rd_addr <= FIRST_A;
            wsum       <= '0;
            rsum       <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_preloader.sv
// Bench for regfile_preloader: table vectors, hand sequences and randomized loads against an image/timeline model.
module tb_regfile_preloader;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int FIRST = 1;
  localparam int LAST  = 31;
  localparam int NREG  = LAST - FIRST + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          rf_we;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          cpu_hold;
  logic          done;
  logic          error;

  logic          stuck;
  logic          tb_init;
  logic [DW-1:0] regs     [0:31];
  logic [DW-1:0] exp_data [0:31];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic          st;
    logic          vl;
    logic [DW-1:0] dat;
    logic          rdy;
    logic          we;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t tbl [8];

  regfile_preloader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIRST_REG (FIRST),
    .LAST_REG  (LAST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .rf_we     (rf_we),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Register file model with an optional stuck-at-1 on bit 3 of reg 7 (read path only).
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'hdead_0000 | DW'(i);
    end else if (rf_we) begin
      regs[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data = regs[rf_rd_addr] | ((stuck && rf_rd_addr == AW'(7)) ? 32'h8 : 32'h0);

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (rf_we) chk("reg0_protect", DW'(rf_wr_addr != '0), 1);
  end

  task automatic cyc_drive(input logic st, input logic vl, input logic [DW-1:0] d);
    @(negedge clk);
    start      = st;
    load_valid = vl;
    load_data  = d;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset      = 1'b1;
    start      = 1'b0;
    load_valid = 1'b1;
    load_data  = $urandom;
    @(negedge clk);
    #1;
    chk("rst_ready", DW'(load_ready), 0);
    chk("rst_we", DW'(rf_we), 0);
    chk("rst_flags", DW'({cpu_hold, done, error}), 32'b100);
    chk("rst_wr_addr", DW'(rf_wr_addr), DW'(FIRST));
    chk("rst_rd_addr", DW'(rf_rd_addr), DW'(FIRST));
    reset      = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic fill(input int mode, input bit corrupt);
    for (int i = 0; i < 32; i++) exp_data[i] = (mode == 2) ? $urandom : DW'(10 * i);
    if (corrupt) exp_data[7] = '0;
  endtask

  // Drives words first_idx..LAST; mode 0 back-to-back, 1 every other cycle, 2 random gaps and stray start.
  task automatic feed(input int first_idx, input int mode, output int cycles);
    int idx;
    bit v;
    idx    = first_idx;
    cycles = 0;
    while (idx <= LAST && cycles < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      cyc_drive((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0, v, v ? exp_data[idx] : $urandom);
      chk("wr_ready", DW'(load_ready), 1);
      chk("wr_we", DW'(rf_we), DW'(v));
      chk("wr_addr", DW'(rf_wr_addr), DW'(idx));
      chk("wr_flags", DW'({cpu_hold, done, error}), 32'b100);
      if (v) begin
        chk("wr_data", rf_wr_data, exp_data[idx]);
        idx++;
      end
      cycles++;
    end
    chk("feed_complete", DW'(idx), DW'(LAST + 1));
  endtask

  task automatic readback(input bit exp_err);
    for (int k = 0; k < NREG; k++) begin
      cyc_drive(1'b0, 1'($urandom_range(0, 1)), $urandom);
      chk("rb_addr", DW'(rf_rd_addr), DW'(FIRST + k));
      chk("rb_quiet", DW'({load_ready, rf_we, done, error, cpu_hold}), 32'b00001);
    end
    cyc_drive(1'b0, 1'b0, '0);
    chk("final_done", DW'(done), DW'(!exp_err));
    chk("final_error", DW'(error), DW'(exp_err));
    chk("final_hold", DW'(cpu_hold), DW'(exp_err));
  endtask

  task automatic check_regs;
    for (int i = FIRST; i <= LAST; i++) chk("reg_image", regs[i], exp_data[i]);
    chk("reg0_kept", regs[0], 32'hdead_0000);
  endtask

  task automatic do_load(input int mode, input bit corrupt, output int cycles);
    bit exp_err;
    fill(mode, corrupt);
    cyc_drive(1'b1, 1'b1, $urandom);
    chk("start_ready", DW'(load_ready), 0);
    chk("start_we", DW'(rf_we), 0);
    feed(FIRST, mode, cycles);
    exp_err = stuck && (exp_data[7][3] == 1'b0);
    readback(exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset      = 1'b1;
    start      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    stuck      = 1'b0;
    tb_init    = 1'b1;
    @(negedge clk);
    tb_init = 1'b0;

    // Full load without gaps, then ignored inputs in DONE.
    do_reset();
    do_load(0, 1'b0, c);
    chk("t1_write_cycles", DW'(c), 31);
    check_regs();
    for (int k = 0; k < 4; k++) begin
      cyc_drive(1'b1, 1'b1, $urandom);
      chk("done_sticky", DW'({done, cpu_hold, rf_we, load_ready}), 32'b1000);
    end

    // Valid every other cycle.
    do_reset();
    do_load(1, 1'b0, c);
    chk("t2_write_cycles", DW'(c), 61);
    check_regs();

    // Corrupt readback, then retry with the fault removed.
    do_reset();
    stuck = 1'b1;
    do_load(0, 1'b1, c);
    for (int k = 0; k < 3; k++) begin
      cyc_drive(1'b0, 1'b1, $urandom);
      chk("err_hold", DW'({error, done, cpu_hold, load_ready, rf_we}), 32'b10100);
    end
    stuck = 1'b0;
    do_load(2, 1'b0, c);
    check_regs();

    // Reset on the cycle reg 12 is accepted.
    do_reset();
    fill(2, 1'b0);
    cyc_drive(1'b1, 1'b0, '0);
    for (int i = 1; i <= 11; i++) cyc_drive(1'b0, 1'b1, exp_data[i]);
    @(negedge clk);
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = exp_data[12];
    #1;
    chk("t4_we12", DW'({rf_we, rf_wr_addr}), DW'({1'b1, 5'd12}));
    cyc_drive(1'b0, 1'b1, $urandom);
    reset = 1'b0;
    chk("t4_after_rst", DW'({load_ready, rf_we, cpu_hold, done, error}), 32'b00100);
    chk("t4_addr", DW'(rf_wr_addr), DW'(FIRST));
    chk("t4_reg12_kept", regs[12], exp_data[12]);

    // Table vectors straight from IDLE: load_valid ignored, start ignored in WRITE, gaps stall.
    fill(0, 1'b0);
    exp_data[1] = 32'h11;
    exp_data[2] = 32'h22;
    exp_data[3] = 32'h33;
    tbl[0] = '{1'b0, 1'b1, 32'haa, 1'b0, 1'b0, 5'd1};
    tbl[1] = '{1'b0, 1'b1, 32'hbb, 1'b0, 1'b0, 5'd1};
    tbl[2] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 5'd1};
    tbl[3] = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 5'd1};
    tbl[4] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 5'd2};
    tbl[5] = '{1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 5'd2};
    tbl[6] = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 5'd3};
    tbl[7] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 5'd4};
    for (int r = 0; r < 8; r++) begin
      cyc_drive(tbl[r].st, tbl[r].vl, tbl[r].dat);
      chk("tbl_ready", DW'(load_ready), DW'(tbl[r].rdy));
      chk("tbl_we", DW'(rf_we), DW'(tbl[r].we));
      chk("tbl_addr", DW'(rf_wr_addr), DW'(tbl[r].addr));
      if (tbl[r].we) chk("tbl_data", rf_wr_data, tbl[r].dat);
    end
    feed(4, 0, c);
    readback(1'b0);
    check_regs();

    // Randomized loads, with the read fault injected at random.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      stuck = 1'($urandom_range(0, 1));
      do_load(2, 1'b0, c);
      check_regs();
      if (error) begin
        stuck = 1'b0;
        do_load(2, 1'b0, c);
        check_regs();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_preloader.md
Name: regfile_preloader

Overview:
- Boot-time loader that writes an initial register image into the processor register file, then lets the processor run.
- Holds the processor in reset while it works, so every program starts from a known register state instead of all-zeros.
- Reads every written register back and checks it before releasing the processor.
- Sits between the skeleton top level and the regfile write/read debug port. It is the writer for the register state the simulation monitor reads.

Parameters:
- DATA_WIDTH, 32, register word width
- ADDR_WIDTH, 5, register index width
- FIRST_REG, 1, first register loaded; $r0 is never written
- LAST_REG, 31, last register loaded; must satisfy FIRST_REG <= LAST_REG < 2^ADDR_WIDTH

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to begin (or retry) a load
- load_valid  input  1  load_data holds a valid word
- load_data  input  DATA_WIDTH  next register value, in ascending register order
- load_ready  output  1  loader accepts a word this cycle
- rf_we  output  1  regfile write enable
- rf_wr_addr  output  ADDR_WIDTH  regfile write index
- rf_wr_data  output  DATA_WIDTH  regfile write data
- rf_rd_addr  output  ADDR_WIDTH  regfile readback index
- rf_rd_data  input  DATA_WIDTH  regfile readback data; combinational read of rf_rd_addr
- cpu_hold  output  1  active-high; ORed into the processor reset
- done  output  1  load complete and verified
- error  output  1  readback mismatch detected

Behaviour:
- Reset (synchronous, active-high):
  - Next state is IDLE.
  - cpu_hold=1; done=0; error=0; load_ready=0; rf_we=0.
  - rf_wr_addr=FIRST_REG, rf_rd_addr=FIRST_REG.
  - Both checksums cleared to 0.
- Reset mid-operation: same result as above. Registers already written are not undone.
- States: IDLE, WRITE, READBACK, DONE, ERROR.
- IDLE:
  - load_ready=0; load_valid is ignored.
  - start=1 -> WRITE; write pointer=FIRST_REG; wsum=0.
- WRITE:
  - load_ready=1.
  - rf_we = load_valid & load_ready (combinational, same cycle). rf_wr_addr = write pointer. rf_wr_data = load_data.
  - On each accepted word: wsum ^= load_data; write pointer increments.
  - Gaps in load_valid stall the pointer; addresses stay contiguous.
  - Accepting the word at LAST_REG -> READBACK; read pointer=FIRST_REG; rsum=0. load_ready is 0 from the next cycle.
  - start is ignored while in WRITE.
- READBACK:
  - One register per cycle; rf_rd_addr = read pointer; rsum ^= rf_rd_data.
  - At LAST_REG the final compare uses rsum ^ rf_rd_data against wsum:
    - equal -> DONE
    - unequal -> ERROR
  - Duration: exactly LAST_REG-FIRST_REG+1 cycles.
  - rf_we=0 and load_ready=0 throughout.
- DONE:
  - done=1; cpu_hold=0.
  - Terminal until reset; start and load_valid are ignored.
- ERROR:
  - error=1; cpu_hold=1.
  - start=1 -> WRITE with error cleared the next cycle, pointers and wsum reset (full reload).
- All outputs except rf_we and rf_wr_data are registered.
- Register 0 is never written in any state; rf_we=1 only when rf_wr_addr is in FIRST_REG..LAST_REG.
- Width rule: checksums are DATA_WIDTH-bit XOR with no carry. Pointers never wrap past LAST_REG.

Test Plan:
1. Full load, no gaps:
   - Stimulus: reset, then start in cycle 0; load_valid held 1 with data=10*i for register i.
   - Required: rf_we pulses in cycles 1..31 with addr 1..31; load_ready=0 from cycle 32; readback in cycles 32..62; done=1 and cpu_hold=0 from cycle 63.
   - Monitor afterwards shows reg1=10 ... reg9=90.
2. Valid bubbles:
   - Stimulus: load_valid high every other cycle.
   - Required: exactly 31 writes to addr 1..31 in order; no write in gap cycles; done=1 after readback.
3. Corrupt readback:
   - Stimulus: regfile model forces bit 3 of reg 7 stuck at 1; reg 7 is written with 0.
   - Required: error=1, done=0, cpu_hold=1.
   - Follow-up: pulse start with the model fixed -> a second full write pass, then done=1 and error=0.
4. Reset mid-WRITE:
   - Stimulus: assert reset on the cycle the word for reg 12 is accepted.
   - Required: next cycle IDLE, load_ready=0, rf_we=0, cpu_hold=1. A new start begins again at addr 1.
5. Ignored inputs:
   - Stimulus: load_valid=1 in IDLE; start=1 in WRITE and in DONE.
   - Required: no extra rf_we; write pointer unaffected; done stays 1.
6. Register 0 protection:
   - Stimulus: random data over all scenarios.
   - Required: rf_we=1 with rf_wr_addr=0 never occurs (assertion).
